// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU in the execute stage.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_Q102H,
    input  logic [1:0]       op_Q102H,
    input  logic [WIDTH-1:0] dividend_Q102H,
    input  logic [WIDTH-1:0] divisor_Q102H,
    input  logic             flush_Q102H,
    output logic             stall_Q102H,
    output logic             done_Q102H,
    output logic [WIDTH-1:0] result_Q102H
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [WIDTH-1:0] dsr_reg, dsr_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             is_rem_reg, is_rem_next;
    logic             neg_q_reg, neg_q_next;
    logic             neg_r_reg, neg_r_next;

    // Operand conditioning for the instruction being offered in IDLE
    logic             is_signed, a_neg, b_neg, div_zero, overflow;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign is_signed = ~op_Q102H[0];
    assign a_neg     = is_signed & dividend_Q102H[WIDTH-1];
    assign b_neg     = is_signed & divisor_Q102H[WIDTH-1];
    assign abs_a     = a_neg ? -dividend_Q102H : dividend_Q102H;
    assign abs_b     = b_neg ? -divisor_Q102H : divisor_Q102H;
    assign div_zero  = (divisor_Q102H == '0);
    assign overflow  = is_signed && (dividend_Q102H == {1'b1, {(WIDTH-1){1'b0}}})
                       && (divisor_Q102H == '1);

    // One restoring step; the shifted remainder needs WIDTH+1 bits when the divisor is large
    logic [WIDTH:0]   rem_wide, trial;
    logic [WIDTH-1:0] step_rem, step_quo, fixed_q, fixed_r;

    assign rem_wide = {rem_reg, quo_reg[WIDTH-1]};
    assign trial    = rem_wide - {1'b0, dsr_reg};
    assign step_rem = trial[WIDTH] ? rem_wide[WIDTH-1:0] : trial[WIDTH-1:0];
    assign step_quo = {quo_reg[WIDTH-2:0], ~trial[WIDTH]};
    assign fixed_q  = neg_q_reg ? -step_quo : step_quo;
    assign fixed_r  = neg_r_reg ? -step_rem : step_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dsr_reg    <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
            is_rem_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rem_reg    <= rem_next;
            quo_reg    <= quo_next;
            dsr_reg    <= dsr_next;
            result_reg <= result_next;
            cnt_reg    <= cnt_next;
            is_rem_reg <= is_rem_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rem_next    = rem_reg;
        quo_next    = quo_reg;
        dsr_next    = dsr_reg;
        result_next = result_reg;
        cnt_next    = cnt_reg;
        is_rem_next = is_rem_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        stall_Q102H = 1'b0;
        done_Q102H  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_Q102H && !flush_Q102H) begin
                    stall_Q102H = 1'b1;
                    is_rem_next = op_Q102H[1];
                    neg_q_next  = a_neg ^ b_neg;
                    neg_r_next  = a_neg;
                    dsr_next    = abs_b;
                    if (div_zero) begin
                        result_next = op_Q102H[1] ? dividend_Q102H : '1;
                        state_next  = DONE;
                    end else if (overflow) begin
                        result_next = op_Q102H[1] ? '0 : dividend_Q102H;
                        state_next  = DONE;
                    end else begin
                        rem_next   = '0;
                        quo_next   = abs_a;
                        cnt_next   = CW'(WIDTH);
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                stall_Q102H = 1'b1;
                if (flush_Q102H) begin
                    state_next = IDLE;
                end else begin
                    rem_next = step_rem;
                    quo_next = step_quo;
                    cnt_next = cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        result_next = is_rem_reg ? fixed_r : fixed_q;
                        state_next  = DONE;
                    end
                end
            end
            DONE: begin
                // A killed instruction must not be seen as completing
                done_Q102H = ~flush_Q102H;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign result_Q102H = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: arithmetic, special cases, flush,
// mid-operation reset and back-to-back timing.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        stall, done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    div_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_Q102H   (start),
        .op_Q102H      (op),
        .dividend_Q102H(a),
        .divisor_Q102H (b),
        .flush_Q102H   (flush),
        .stall_Q102H   (stall),
        .done_Q102H    (done),
        .result_Q102H  (result)
    );

    // Issue one op at the current cycle (entered #1 after a rising edge) and measure it.
    // Returns #1 after the edge that follows the done cycle.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic st0, output logic st_run,
                         output logic st_done, output logic [31:0] res);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        st0 = stall;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        st_run = 1'b1;
        @(negedge clk);
        while (done !== 1'b1 && lat < 200) begin
            if (stall !== 1'b1) st_run = 1'b0;
            @(negedge clk);
            lat++;
        end
        st_done = stall;
        res = result;
        $display("op=%0d a=%h b=%h result=%h latency=%0d", o, x, y, res, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset: stall=%b done=%b result=%h, required 0 0 00000000", stall, done, result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [1:0]  ops [9] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_REM, OP_DIV, OP_REMU, OP_DIVU, OP_REMU};
        logic [31:0] xs  [9] = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7,
                                 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ys  [9] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFFFFFE,
                                 32'd2, 32'h10, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] exp [9] = '{32'd14, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1,
                                 32'hC0000000, 32'hF, 32'd1, 32'd1};
        int lat;
        logic st0, st_run, st_done;
        logic [31:0] res;
        for (int i = 0; i < 9; i++) begin
            do_op(ops[i], xs[i], ys[i], lat, st0, st_run, st_done, res);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("FAIL arith_result[%0d]: got %h, required %h", i, res, exp[i]);
            end
            checks++;
            if (lat !== 33) begin
                errors++;
                $display("FAIL arith_latency[%0d]: got %0d, required 33", i, lat);
            end
            checks++;
            if (st0 !== 1'b1 || st_run !== 1'b1 || st_done !== 1'b0) begin
                errors++;
                $display("FAIL arith_stall[%0d]: start=%b run=%b done=%b, required 1 1 0", i, st0, st_run, st_done);
            end
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL arith_done_pulse[%0d]: done=%b after done cycle, required 0", i, done);
            end
        end
    endtask

    task automatic test_special();
        logic [1:0]  ops [5] = '{OP_DIVU, OP_REM, OP_DIV, OP_DIV, OP_REM};
        logic [31:0] xs  [5] = '{32'd5, 32'd5, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
        logic [31:0] ys  [5] = '{32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        int lat;
        logic st0, st_run, st_done;
        logic [31:0] res;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], xs[i], ys[i], lat, st0, st_run, st_done, res);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("FAIL special_result[%0d]: got %h, required %h", i, res, exp[i]);
            end
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL special_latency[%0d]: got %0d, required 1", i, lat);
            end
            checks++;
            if (st0 !== 1'b1 || st_done !== 1'b0) begin
                errors++;
                $display("FAIL special_stall[%0d]: start=%b done=%b, required 1 0", i, st0, st_done);
            end
        end
    endtask

    task automatic test_flush();
        int lat;
        logic st0, st_run, st_done, saw_done;
        logic [31:0] res;
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;   // cycle T
        @(posedge clk); #1;
        start = 1'b0;                                         // cycle T+1
        saw_done = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b1;                                         // cycle T+10
        @(negedge clk);
        if (done === 1'b1) saw_done = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;                                         // cycle T+11
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || saw_done !== 1'b0) begin
            errors++;
            $display("FAIL flush: stall=%b done=%b early_done=%b, required 0 0 0", stall, done, saw_done);
        end
        do_op(OP_DIVU, 32'd100, 32'd7, lat, st0, st_run, st_done, res);
        checks++;
        if (lat !== 33 || res !== 32'd14 || st0 !== 1'b1) begin
            errors++;
            $display("FAIL flush_restart: latency=%0d result=%h stall=%b, required 33 0000000e 1", lat, res, st0);
        end
    endtask

    task automatic test_reset_midop();
        int lat1, lat2, s0, s1;
        logic st0, st_run, st_done;
        logic [31:0] res;
        start = 1'b1; op = OP_DIVU; a = 32'hFFFFFFFF; b = 32'd1; // cycle T
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;                                            // cycle T+20
        @(posedge clk); #1;
        rst = 1'b0;                                            // cycle T+21
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_midop: stall=%b done=%b result=%h, required 0 0 00000000", stall, done, result);
        end
        @(posedge clk); #1;
        s0 = cyc;
        do_op(OP_DIVU, 32'hFFFFFFFF, 32'd1, lat1, st0, st_run, st_done, res);
        checks++;
        if (lat1 !== 33 || res !== 32'hFFFFFFFF || st0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: latency=%0d result=%h stall=%b, required 33 ffffffff 1", lat1, res, st0);
        end
        s1 = cyc;
        do_op(OP_DIVU, 32'hFFFFFFFF, 32'd1, lat2, st0, st_run, st_done, res);
        checks++;
        if ((s1 - s0) + lat2 !== 67 || res !== 32'hFFFFFFFF || st0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: done_at=T+%0d result=%h stall=%b, required T+67 ffffffff 1",
                     (s1 - s0) + lat2, res, st0);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_special();
        test_flush();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the execute stage (Q102H) beside the ALU and takes the same post-forwarding operands the ALU uses. While it runs it stalls the front of the pipeline, then presents one result for the Q102H→Q103H register to capture.

## Interface

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_Q102H  in  1  divide instruction present in Q102H.
- op_Q102H  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_Q102H  in  WIDTH  rs1 value after forwarding.
- divisor_Q102H  in  WIDTH  rs2 value after forwarding.
- flush_Q102H  in  1  kill the instruction in Q102H (branch redirect).
- stall_Q102H  out  1  hold Q101H/Q102H registers this cycle.
- done_Q102H  out  1  one-cycle pulse: result_Q102H valid, pipeline may advance.
- result_Q102H  out  WIDTH  quotient or remainder per latched op.

## Operation

- States: IDLE, RUN, DONE.
- IDLE: start_Q102H=1 and flush_Q102H=0 accepts the instruction.
  - Latch op, the operand signs, |dividend| and |divisor|. Unsigned ops take the operands as-is.
  - If the divisor is zero or the operation is a signed overflow, go to DONE with the result precomputed.
  - Otherwise clear the remainder register, load the quotient register with |dividend| and the counter with WIDTH, then go to RUN.
- RUN: one restoring step per cycle.
  - Shift {rem,quo} left by 1 and form trial = rem − |divisor| in WIDTH+1 bits.
  - If trial ≥ 0: rem=trial, quo[0]=1. Else quo[0]=0.
  - Decrement the counter. The step that brings it to 0 moves the block to DONE.
- DONE: drive done_Q102H=1 and result_Q102H, then go to IDLE. start_Q102H is ignored in DONE because it still belongs to the finishing instruction.
- Sign fix-up, applied when entering DONE:
  - Signed quotient is negated iff sign(a)≠sign(b).
  - Signed remainder takes the sign of the dividend.
- Special cases, per the RISC-V spec:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = 0x80000000, divisor = −1): quotient = 0x80000000; remainder = 0.
- stall_Q102H = (IDLE & start_Q102H & ~flush_Q102H) | RUN. It is 0 in DONE.
- flush_Q102H=1 in RUN or DONE returns the block to IDLE on the next edge with no done pulse. It has priority over every other transition.
- Only the next rising edge can be a reset edge: rst=1 forces IDLE, and all outputs return to their reset values on the following cycle.

## Timing

- Reset values: stall_Q102H=0, done_Q102H=0, result_Q102H=0, state=IDLE, counter=0.
- Normal op, start accepted at cycle T:
  - RUN during T+1..T+WIDTH.
  - DONE at T+WIDTH+1, so done_Q102H is high at T+33 for WIDTH=32.
  - stall_Q102H is high T..T+32 and low at T+33.
  - Back in IDLE at T+34; a new start is accepted at T+34.
- Special-case op: DONE at T+1, so stall_Q102H is high only at T and done_Q102H is high at T+1.
- result_Q102H holds its last value outside DONE. The consumer samples it only when done_Q102H=1.
- Back-to-back divides: the second start is accepted no earlier than the cycle after DONE. There is no bubble beyond that cycle.

## Test plan

- DIVU 100/7: start at T, done at T+33 → result 14. Same operands with REMU → 2.
- DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). REM 7/−2 → 1.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both with done at T+1 and stall only at T.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, with done at T+1.
- Flush at T+10 of a DIVU → no done pulse, stall low from T+11, IDLE at T+11. A new start at T+11 then completes normally at T+44.
- Reset asserted at T+20 mid-op → at T+21 all outputs are 0 and the block is IDLE. Two consecutive DIVU 0xFFFFFFFF/1 complete at T+33 and T+67, each with result 0xFFFFFFFF.
